// File: rtl/batalha_pkg.sv
// Shared definitions for the fleet placement validator: ship codes, cell counts,
// FSM states and record field layout helpers.
package batalha_pkg;

    typedef enum logic [2:0] {
        TIPO_PORTA_AVIOES = 3'd0,
        TIPO_ENCOURACADO  = 3'd1,
        TIPO_HIDROAVIAO   = 3'd2,
        TIPO_CRUZADOR     = 3'd3,
        TIPO_SUBMARINO    = 3'd4
    } tipo_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUILD  = 3'd1,
        SCAN   = 3'd2,
        WRITE  = 3'd3,
        REPORT = 3'd4
    } estado_e;

    localparam int TIPO_LSB  = 0;
    localparam int TIPO_W    = 3;
    localparam int CELL_LSB  = 3;
    localparam int MAX_CELLS = 5;
    localparam int CNT_W     = 4;

    localparam logic [CNT_W-1:0] CNT_PORTA_AVIOES = 4'd5;
    localparam logic [CNT_W-1:0] CNT_ENCOURACADO  = 4'd4;
    localparam logic [CNT_W-1:0] CNT_HIDROAVIAO   = 4'd3;
    localparam logic [CNT_W-1:0] CNT_CRUZADOR     = 4'd2;
    localparam logic [CNT_W-1:0] CNT_SUBMARINO    = 4'd1;

    function automatic int cell_x_lsb(input int k, input int cw);
        return CELL_LSB + 2 * k * cw;
    endfunction

    function automatic int cell_y_lsb(input int k, input int cw);
        return CELL_LSB + (2 * k + 1) * cw;
    endfunction

endpackage

// File: rtl/forma_navio.sv
// Combinational ship shape builder: expands type/direction/anchor into up to
// five cells, the cell count and a border/illegal-shape flag.
module forma_navio
    import batalha_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int COORD_W = 4
) (
    input  logic [2:0]                        tipo_i,
    input  logic                              direcao_i,
    input  logic [1:0]                        orientacao_i,
    input  logic [COORD_W-1:0]                x_i,
    input  logic [COORD_W-1:0]                y_i,
    output logic [MAX_CELLS-1:0][COORD_W-1:0] cel_x_o,
    output logic [MAX_CELLS-1:0][COORD_W-1:0] cel_y_o,
    output logic [CNT_W-1:0]                  contagem_o,
    output logic                              borda_o
);

    // Two guard bits: one for the +4 overshoot, one as the underflow sign.
    localparam int EW = COORD_W + 2;

    logic signed [3:0]    dx_s [MAX_CELLS];
    logic signed [3:0]    dy_s [MAX_CELLS];
    logic signed [EW-1:0] ex_s [MAX_CELLS];
    logic signed [EW-1:0] ey_s [MAX_CELLS];
    logic                 invalido_s;

    // Per-cell offsets relative to the anchor, and shape legality.
    always_comb begin
        contagem_o = '0;
        invalido_s = 1'b0;
        for (int k = 0; k < MAX_CELLS; k++) begin
            dx_s[k] = 4'sd0;
            dy_s[k] = 4'sd0;
        end
        case (tipo_i)
            TIPO_PORTA_AVIOES: contagem_o = CNT_PORTA_AVIOES;
            TIPO_ENCOURACADO:  contagem_o = CNT_ENCOURACADO;
            TIPO_HIDROAVIAO:   contagem_o = CNT_HIDROAVIAO;
            TIPO_CRUZADOR:     contagem_o = CNT_CRUZADOR;
            TIPO_SUBMARINO:    contagem_o = CNT_SUBMARINO;
            default: begin
                contagem_o = '0;
                invalido_s = 1'b1;
            end
        endcase
        if (tipo_i == TIPO_HIDROAVIAO) begin
            case (orientacao_i)
                2'd0: begin
                    dx_s[1] = 4'sd1; dy_s[1] = 4'sd1; dx_s[2] = 4'sd2;
                    invalido_s = direcao_i;
                end
                2'd1: begin
                    dx_s[1] = 4'sd1; dy_s[1] = -4'sd1; dx_s[2] = 4'sd2;
                    invalido_s = direcao_i;
                end
                2'd2: begin
                    dx_s[1] = 4'sd1; dy_s[1] = 4'sd1; dy_s[2] = 4'sd2;
                    invalido_s = ~direcao_i;
                end
                2'd3: begin
                    dx_s[1] = -4'sd1; dy_s[1] = 4'sd1; dy_s[2] = 4'sd2;
                    invalido_s = ~direcao_i;
                end
                default: invalido_s = 1'b1;
            endcase
        end else begin
            for (int k = 0; k < MAX_CELLS; k++) begin
                if (4'(k) < contagem_o) begin
                    if (direcao_i) begin
                        dy_s[k] = 4'(k);
                    end else begin
                        dx_s[k] = 4'(k);
                    end
                end else begin
                    dx_s[k] = 4'sd0;
                    dy_s[k] = 4'sd0;
                end
            end
        end
    end

    // Absolute cells; a negative result reads as a huge unsigned value, so a
    // single unsigned compare covers both overflow and underflow.
    always_comb begin
        borda_o = invalido_s;
        for (int k = 0; k < MAX_CELLS; k++) begin
            ex_s[k] = $signed({2'b00, x_i}) + EW'(dx_s[k]);
            ey_s[k] = $signed({2'b00, y_i}) + EW'(dy_s[k]);
            if (4'(k) < contagem_o) begin
                borda_o = borda_o | ($unsigned(ex_s[k]) >= EW'(BOARD_W))
                                  | ($unsigned(ey_s[k]) >= EW'(BOARD_W));
                cel_x_o[k] = ex_s[k][COORD_W-1:0];
                cel_y_o[k] = ey_s[k][COORD_W-1:0];
            end else begin
                cel_x_o[k] = '0;
                cel_y_o[k] = '0;
            end
        end
    end

endmodule

// File: rtl/validador_frota.sv
// Fleet placement validator: builds a ship record, scans the player's stored
// records for collisions and appends it when legal. Option: ADJACENCY_CHECK_EN.
module validador_frota
    import batalha_pkg::*;
#(
    parameter int  BOARD_W    = 10,
    parameter int  COORD_W    = 4,
    parameter int  SHIP_SLOTS = 11,
    parameter int  PLAYERS    = 2,
    localparam int REC_W      = 3 + 10 * COORD_W + 4,
    localparam int AW         = $clog2(SHIP_SLOTS),
    localparam int JW         = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         tipo,
    input  logic               direcao,
    input  logic [1:0]         orientacao,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [JW-1:0]      jogador,
    output logic [AW-1:0]      rd_addr,
    input  logic [REC_W-1:0]   rd_data,
    output logic [PLAYERS-1:0] wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [REC_W-1:0]   wr_data,
    output logic               done,
    output logic               conflito_borda,
    output logic               conflito_memoria,
    output logic               frota_cheia,
    output logic               conflito
);

    localparam int FW = $clog2(SHIP_SLOTS + 1);

    estado_e              state_q, state_d;
    logic [2:0]           tipo_q, tipo_d;
    logic                 dir_q, dir_d;
    logic [1:0]           ori_q, ori_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [JW-1:0]        jog_q, jog_d;
    logic [REC_W-1:0]     rec_s, rec_q, rec_d;
    logic [FW-1:0]        scan_q, scan_d;
    logic [FW-1:0]        fill_q [PLAYERS];
    logic [FW-1:0]        fill_d [PLAYERS];
    logic [FW-1:0]        fill_cur_s;
    logic                 req_ready_q, req_ready_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic [PLAYERS-1:0]   wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [REC_W-1:0]     wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic                 borda_q, borda_d;
    logic                 mem_q, mem_d;
    logic                 cheia_q, cheia_d;
    logic                 conf_q, conf_d;
    logic                 hit_s;
    logic                 arm_ok_s;
    logic [CNT_W-1:0]     nov_cnt_s, arm_cnt_s;

    logic [MAX_CELLS-1:0][COORD_W-1:0] cel_x_s, cel_y_s;
    logic [CNT_W-1:0]                  cnt_s;
    logic                              borda_s;

    function automatic logic celula_conflita(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                             input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
`ifdef ADJACENCY_CHECK_EN
        logic [COORD_W-1:0] ddx, ddy;
        ddx = (ax > bx) ? (ax - bx) : (bx - ax);
        ddy = (ay > by) ? (ay - by) : (by - ay);
        return (ddx <= COORD_W'(1)) && (ddy <= COORD_W'(1));
`else
        return (ax == bx) && (ay == by);
`endif
    endfunction

    forma_navio #(
        .BOARD_W (BOARD_W),
        .COORD_W (COORD_W)
    ) u_forma (
        .tipo_i       (tipo_q),
        .direcao_i    (dir_q),
        .orientacao_i (ori_q),
        .x_i          (x_q),
        .y_i          (y_q),
        .cel_x_o      (cel_x_s),
        .cel_y_o      (cel_y_s),
        .contagem_o   (cnt_s),
        .borda_o      (borda_s)
    );

    // Pack the shape into the stored record layout.
    always_comb begin
        rec_s = '0;
        rec_s[TIPO_LSB +: TIPO_W] = tipo_q;
        for (int k = 0; k < MAX_CELLS; k++) begin
            rec_s[cell_x_lsb(k, COORD_W) +: COORD_W] = cel_x_s[k];
            rec_s[cell_y_lsb(k, COORD_W) +: COORD_W] = cel_y_s[k];
        end
        rec_s[REC_W-1 -: CNT_W] = cnt_s;
    end

    // All-pairs cell comparison of the new record against the record on rd_data.
    always_comb begin
        hit_s     = 1'b0;
        nov_cnt_s = rec_q[REC_W-1 -: CNT_W];
        arm_cnt_s = rd_data[REC_W-1 -: CNT_W];
        // A slot carrying an illegal type code is never trusted as a ship.
        arm_ok_s  = (rd_data[TIPO_LSB +: TIPO_W] <= TIPO_SUBMARINO);
        for (int i = 0; i < MAX_CELLS; i++) begin
            for (int j = 0; j < MAX_CELLS; j++) begin
                hit_s = hit_s | (arm_ok_s & (4'(i) < nov_cnt_s) & (4'(j) < arm_cnt_s) &
                        celula_conflita(rec_q[cell_x_lsb(i, COORD_W) +: COORD_W],
                                        rec_q[cell_y_lsb(i, COORD_W) +: COORD_W],
                                        rd_data[cell_x_lsb(j, COORD_W) +: COORD_W],
                                        rd_data[cell_y_lsb(j, COORD_W) +: COORD_W]));
            end
        end
    end

    // Fill level of the captured player.
    always_comb begin
        fill_cur_s = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (JW'(p) == jog_q) begin
                fill_cur_s = fill_q[p];
            end else begin
                fill_cur_s = fill_cur_s;
            end
        end
    end

    // FSM next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        tipo_d    = tipo_q;
        dir_d     = dir_q;
        ori_d     = ori_q;
        x_d       = x_q;
        y_d       = y_q;
        jog_d     = jog_q;
        rec_d     = rec_q;
        scan_d    = scan_q;
        rd_addr_d = '0;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        borda_d   = borda_q;
        mem_d     = mem_q;
        cheia_d   = cheia_q;
        for (int p = 0; p < PLAYERS; p++) begin
            fill_d[p] = fill_q[p];
        end
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tipo_d  = tipo;
                    dir_d   = direcao;
                    ori_d   = orientacao;
                    x_d     = x1;
                    y_d     = y1;
                    jog_d   = jogador;
                    borda_d = 1'b0;
                    mem_d   = 1'b0;
                    cheia_d = 1'b0;
                    state_d = BUILD;
                end else begin
                    state_d = IDLE;
                end
            end
            BUILD: begin
                rec_d  = rec_s;
                scan_d = '0;
                if (borda_s) begin
                    borda_d = 1'b1;
                    state_d = REPORT;
                end else if (fill_cur_s == FW'(SHIP_SLOTS)) begin
                    cheia_d = 1'b1;
                    state_d = REPORT;
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // rd_data lags rd_addr by one cycle, so cycle 0 has nothing to compare.
                mem_d = mem_q | ((scan_q != '0) & hit_s);
                if (scan_q == fill_cur_s) begin
                    if (mem_d) begin
                        state_d = REPORT;
                    end else begin
                        wr_en_d   = PLAYERS'(1) << jog_q;
                        wr_addr_d = AW'(fill_cur_s);
                        wr_data_d = rec_q;
                        state_d   = WRITE;
                    end
                end else begin
                    scan_d = scan_q + FW'(1);
                    if (scan_d < fill_cur_s) begin
                        rd_addr_d = AW'(scan_d);
                    end else begin
                        rd_addr_d = '0;
                    end
                end
            end
            WRITE: begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (JW'(p) == jog_q) begin
                        fill_d[p] = fill_q[p] + FW'(1);
                    end else begin
                        fill_d[p] = fill_q[p];
                    end
                end
                state_d = REPORT;
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        done_d      = (state_d == REPORT);
        conf_d      = borda_d | mem_d | cheia_d;
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tipo_q      <= '0;
            dir_q       <= 1'b0;
            ori_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            jog_q       <= '0;
            rec_q       <= '0;
            scan_q      <= '0;
            req_ready_q <= 1'b1;
            rd_addr_q   <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            borda_q     <= 1'b0;
            mem_q       <= 1'b0;
            cheia_q     <= 1'b0;
            conf_q      <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                fill_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tipo_q      <= tipo_d;
            dir_q       <= dir_d;
            ori_q       <= ori_d;
            x_q         <= x_d;
            y_q         <= y_d;
            jog_q       <= jog_d;
            rec_q       <= rec_d;
            scan_q      <= scan_d;
            req_ready_q <= req_ready_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            borda_q     <= borda_d;
            mem_q       <= mem_d;
            cheia_q     <= cheia_d;
            conf_q      <= conf_d;
            for (int p = 0; p < PLAYERS; p++) begin
                fill_q[p] <= fill_d[p];
            end
        end
    end

    assign req_ready        = req_ready_q;
    assign rd_addr          = rd_addr_q;
    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign done             = done_q;
    assign conflito_borda   = borda_q;
    assign conflito_memoria = mem_q;
    assign frota_cheia      = cheia_q;
    assign conflito         = conf_q;

endmodule

// File: tb/tb_validador_frota.sv
// Directed bench for validador_frota with a two-player record memory model.
module tb_validador_frota;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  tipo;
    logic        direcao;
    logic [1:0]  orientacao;
    logic [3:0]  x1, y1;
    logic        jogador;
    logic [3:0]  rd_addr;
    logic [46:0] rd_data;
    logic [1:0]  wr_en;
    logic [3:0]  wr_addr;
    logic [46:0] wr_data;
    logic        done, conflito_borda, conflito_memoria, frota_cheia, conflito;

    logic [46:0] mem [2][16];
    logic        cur_jog = 1'b0;
    int          wr_cnt = 0;
    int          rd_nz = 0;
    logic [1:0]  last_en = 2'b00;
    logic [3:0]  last_addr = 4'd0;
    logic [46:0] last_data = '0;

    int n_checks = 0;
    int n_fail = 0;
    int lat;
    int f0 = 0;
    int wr0, rd0;

    validador_frota dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .tipo(tipo), .direcao(direcao), .orientacao(orientacao), .x1(x1), .y1(y1),
        .jogador(jogador), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .conflito_borda(conflito_borda),
        .conflito_memoria(conflito_memoria), .frota_cheia(frota_cheia), .conflito(conflito)
    );

    always #5 clk = ~clk;

    // Synchronous-read record memory per player plus write/read-activity monitors.
    always @(posedge clk) begin
        if (wr_en[0]) mem[0][wr_addr] <= wr_data;
        if (wr_en[1]) mem[1][wr_addr] <= wr_data;
        if (wr_en != 2'b00) begin
            wr_cnt    <= wr_cnt + 1;
            last_en   <= wr_en;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (rd_addr != 4'd0) rd_nz <= rd_nz + 1;
        rd_data <= mem[cur_jog][rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] pack(input logic [2:0] t, input logic [3:0] c,
                                         input logic [19:0] xs, input logic [19:0] ys);
        logic [46:0] r;
        r = '0;
        r[2:0] = t;
        for (int k = 0; k < 5; k++) begin
            r[3 + 8*k +: 4] = xs[4*k +: 4];
            r[7 + 8*k +: 4] = ys[4*k +: 4];
        end
        r[46:43] = c;
        return r;
    endfunction

    task automatic drive_accept(input logic [2:0] t, input logic d, input logic [1:0] o,
                                input logic [3:0] x, input logic [3:0] y, input logic j);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 64'(req_ready), 64'd1);
        tipo = t; direcao = d; orientacao = o; x1 = x; y1 = y; jogador = j; cur_jog = j;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tipo = 3'd7; x1 = 4'hF; y1 = 4'hF;
        chk("busy_ready", 64'(req_ready), 64'd0);
    endtask

    task automatic do_req(input logic [2:0] t, input logic d, input logic [1:0] o,
                          input logic [3:0] x, input logic [3:0] y, input logic j, output int l);
        wr0 = wr_cnt;
        rd0 = rd_nz;
        drive_accept(t, d, o, x, y, j);
        l = 0;
        while (!done && l < 60) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!done) l = -1;
    endtask

    task automatic expect_res(input string tag, input int l, input int l_exp, input logic b,
                              input logic m, input logic c, input int nwr);
        chk({tag, "_lat"}, 64'(l), 64'(l_exp));
        chk({tag, "_borda"}, 64'(conflito_borda), 64'(b));
        chk({tag, "_mem"}, 64'(conflito_memoria), 64'(m));
        chk({tag, "_cheia"}, 64'(frota_cheia), 64'(c));
        chk({tag, "_conf"}, 64'(conflito), 64'(b | m | c));
        chk({tag, "_nwr"}, 64'(wr_cnt - wr0), 64'(nwr));
    endtask

    task automatic expect_border(input string tag, input int l);
        expect_res(tag, l, 1, 1'b1, 1'b0, 1'b0, 0);
        chk({tag, "_rd"}, 64'(rd_nz - rd0), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; tipo = 3'd0; direcao = 1'b0; orientacao = 2'd0;
        x1 = 4'd0; y1 = 4'd0; jogador = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_flags", 64'({conflito_borda, conflito_memoria, frota_cheia, conflito}), 64'd0);
        chk("rst_wr", 64'({wr_en, wr_addr}), 64'd0);
        chk("rst_wdata", 64'(wr_data), 64'd0);
        chk("rst_rd", 64'(rd_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Porta-avioes H at (5,2) into an empty memory.
        do_req(3'd0, 1'b0, 2'd0, 4'd5, 4'd2, 1'b0, lat);
        expect_res("pa_ok", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("pa_en", 64'(last_en), 64'b01);
        chk("pa_addr", 64'(last_addr), 64'(f0));
        chk("pa_cnt", 64'(last_data[46:43]), 64'd5);
        chk("pa_data", 64'(last_data), 64'(pack(3'd0, 4'd5, {4'd9, 4'd8, 4'd7, 4'd6, 4'd5}, {5{4'd2}})));
        f0++;

        // Border violations.
        do_req(3'd0, 1'b0, 2'd0, 4'd6, 4'd0, 1'b0, lat);
        expect_border("pa_borda", lat);
        @(posedge clk);
        #1;
        chk("flag_hold", 64'({done, conflito_borda}), 64'b01);
        do_req(3'd2, 1'b1, 2'd3, 4'd0, 4'd0, 1'b0, lat);
        expect_border("hid_under", lat);
        do_req(3'd2, 1'b1, 2'd0, 4'd4, 4'd4, 1'b0, lat);
        expect_border("hid_dir", lat);
        do_req(3'd5, 1'b0, 2'd0, 4'd1, 4'd1, 1'b0, lat);
        expect_border("tipo_inv", lat);
        do_req(3'd1, 1'b1, 2'd0, 4'd9, 4'd7, 1'b0, lat);
        expect_border("enc_over", lat);

        // Cruzador V at (3,3), then overlapping submarino at (3,4).
        do_req(3'd3, 1'b1, 2'd0, 4'd3, 4'd3, 1'b0, lat);
        expect_res("cru_ok", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("cru_addr", 64'(last_addr), 64'(f0));
        chk("cru_data", 64'(last_data), 64'(pack(3'd3, 4'd2, {12'd0, 4'd3, 4'd3}, {12'd0, 4'd4, 4'd3})));
        f0++;
        do_req(3'd4, 1'b0, 2'd0, 4'd3, 4'd4, 1'b0, lat);
        expect_res("sub_overlap", lat, f0 + 2, 1'b0, 1'b1, 1'b0, 0);

        // Submarino beside the cruzador.
        do_req(3'd4, 1'b0, 2'd0, 4'd3, 4'd5, 1'b0, lat);
`ifdef ADJACENCY_CHECK_EN
        expect_res("sub_adj", lat, f0 + 2, 1'b0, 1'b1, 1'b0, 0);
`else
        expect_res("sub_adj", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("sub_adj_addr", 64'(last_addr), 64'(f0));
        f0++;
`endif

        // Hidroaviao orientacao 1 and encouracado V touching the far edge.
        do_req(3'd2, 1'b0, 2'd1, 4'd0, 4'd8, 1'b0, lat);
        expect_res("hid_ok", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("hid_data", 64'(last_data),
            64'(pack(3'd2, 4'd3, {4'd0, 4'd0, 4'd2, 4'd1, 4'd0}, {4'd0, 4'd0, 4'd8, 4'd7, 4'd8})));
        f0++;
        do_req(3'd1, 1'b1, 2'd0, 4'd9, 4'd6, 1'b0, lat);
        expect_res("enc_ok", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("enc_data", 64'(last_data),
            64'(pack(3'd1, 4'd4, {4'd0, 4'd9, 4'd9, 4'd9, 4'd9}, {4'd0, 4'd9, 4'd8, 4'd7, 4'd6})));
        f0++;

        // Fill jogador 1 with 11 submarinos, then a 12th.
        for (int i = 0; i < 11; i++) begin
            do_req(3'd4, 1'b0, 2'd0, 4'(2 * (i % 5)), 4'(2 * (i / 5)), 1'b1, lat);
            expect_res("j1_fill", lat, i + 3, 1'b0, 1'b0, 1'b0, 1);
            chk("j1_addr", 64'({last_en, last_addr}), 64'({2'b10, 4'(i)}));
        end
        do_req(3'd4, 1'b0, 2'd0, 4'd9, 4'd9, 1'b1, lat);
        expect_res("j1_cheia", lat, 1, 1'b0, 1'b0, 1'b1, 0);
        do_req(3'd4, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, lat);
        expect_res("j0_after", lat, f0 + 3, 1'b0, 1'b0, 1'b0, 1);
        chk("j0_after_wr", 64'({last_en, last_addr}), 64'({2'b01, 4'(f0)}));
        f0++;

        // Reset while scanning.
        wr0 = wr_cnt;
        drive_accept(3'd4, 1'b0, 2'd0, 4'd5, 4'd5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_out", 64'({done, wr_en, conflito}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_nwr", 64'(wr_cnt - wr0), 64'd0);
        do_req(3'd4, 1'b0, 2'd0, 4'd5, 4'd5, 1'b0, lat);
        expect_res("rst_j0", lat, 3, 1'b0, 1'b0, 1'b0, 1);
        chk("rst_j0_addr", 64'({last_en, last_addr}), 64'({2'b01, 4'd0}));
        do_req(3'd4, 1'b0, 2'd0, 4'd5, 4'd5, 1'b1, lat);
        expect_res("rst_j1", lat, 3, 1'b0, 1'b0, 1'b0, 1);
        chk("rst_j1_addr", 64'({last_en, last_addr}), 64'({2'b10, 4'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/validador_frota.md
VALIDADOR_FROTA -- requirements
Module: validador_frota

Interface
REQ-001 SHALL take parameter BOARD_W, default 10: board edge in cells; legal coordinates are 0..BOARD_W-1.
REQ-002 SHALL take parameter COORD_W, default 4: coordinate width; BOARD_W <= 2**COORD_W.
REQ-003 SHALL take parameter SHIP_SLOTS, default 11: memory records per player.
REQ-004 SHALL take parameter PLAYERS, default 2: number of player memories.
REQ-005 SHALL use derived constant REC_W = 3 + 10*COORD_W + 4 (47 at defaults) and AW = $clog2(SHIP_SLOTS).
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  placement request.
- req_ready  out  1  high only in IDLE.
- tipo  in  3  ship type: 0 porta-avioes, 1 encouracado, 2 hidroaviao, 3 cruzador, 4 submarino.
- direcao  in  1  0 horizontal, 1 vertical.
- orientacao  in  2  hidroaviao variant, 0..3.
- x1, y1  in  COORD_W  anchor cell.
- jogador  in  max(1,$clog2(PLAYERS))  target player.
- rd_addr  out  AW  record read address.
- rd_data  in  REC_W  record at rd_addr, valid one cycle after rd_addr.
- wr_en  out  PLAYERS  one-hot write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  REC_W  record to store.
- done  out  1  one-cycle result pulse.
- conflito_borda, conflito_memoria, frota_cheia  out  1  result flags; valid while done=1.
- conflito  out  1  OR of the three result flags.

Function
REQ-007 SHALL capture all request inputs on the cycle where req_valid and req_ready are both 1; inputs are ignored at all other times.
REQ-008 SHALL use FSM states IDLE, BUILD, SCAN, WRITE, REPORT; transitions IDLE->BUILD on accept, then BUILD->SCAN, SCAN->WRITE or REPORT, WRITE->REPORT, REPORT->IDLE.
REQ-009 SHALL build the record in BUILD: [2:0] tipo; cell k at [3+2k*COORD_W +: COORD_W] = x and the next COORD_W bits = y, k = 0..4; [REC_W-1 -: 4] = cell count; unused cells zero.
REQ-010 SHALL use these shapes, with H/V advancing x/y by +1 per cell:
- porta-avioes: 5 linear cells.
- encouracado: 4 linear cells.
- cruzador: 2 linear cells.
- submarino: 1 cell.
- hidroaviao (3 cells) by orientacao: 0 (x,y)(x+1,y+1)(x+2,y); 1 (x,y)(x+1,y-1)(x+2,y); 2 (x,y)(x+1,y+1)(x,y+2); 3 (x,y)(x-1,y+1)(x,y+2).
REQ-011 SHALL flag conflito_borda when any cell is >= BOARD_W or any subtraction underflows.
REQ-012 SHALL flag conflito_borda when tipo > 4 or when hidroaviao orientacao is inconsistent with direcao (0/1 require H; 2/3 require V).
REQ-013 SHALL go BUILD->REPORT on border conflict, with no memory access.
REQ-014 SHALL go BUILD->REPORT with frota_cheia when the player's fill counter equals SHIP_SLOTS.
REQ-015 SHALL read slots 0..fill-1 in SCAN, one per cycle, pipelined, and compare every valid new cell against every valid stored cell (index < stored count); any equality sets conflito_memoria.
REQ-016 SHALL take fill+1 cycles in SCAN; fill=0 takes one cycle.
REQ-017 SHALL assert, in WRITE, wr_en[jogador] for exactly one cycle with wr_addr = fill and wr_data = the record; fill then increments.
REQ-018 SHALL pulse done in REPORT; flags hold until the next accept.
REQ-019 SHALL have zero writes on any conflict.

Reset
REQ-020 SHALL, on rst_n low, immediately put the FSM in IDLE and clear to zero: all fill counters, rd_addr, wr_addr, wr_data, wr_en, done, and all flags.
REQ-021 SHALL abandon any request in progress on mid-operation reset, with no write.

Configuration
REQ-022 SHALL, with ADJACENCY_CHECK_EN defined, also flag conflito_memoria when a stored cell is 8-neighbour adjacent (|dx|<=1 and |dy|<=1) to a new cell.
REQ-023 SHALL, without ADJACENCY_CHECK_EN, detect exact overlap only.

Structure
REQ-024 SHALL place ship type codes, cell counts, the FSM state enum and field-offset constants in package batalha_pkg.
REQ-025 SHALL use sub-module forma_navio: combinational shape builder returning cells, count and border flag.

Verification
REQ-026 SHALL cover: empty memory, porta-avioes H at (5,2) -> wr_en[0]=1, wr_addr=0, count field=5, done with all flags 0.
REQ-027 SHALL cover: porta-avioes H at (6,0), BOARD_W=10 -> conflito_borda=1, no wr_en, no rd_addr activity.
REQ-028 SHALL cover: cruzador V at (3,3) stored, then submarino at (3,4) -> conflito_memoria=1, fill unchanged.
REQ-029 SHALL cover: submarino at (3,5) beside the cruzador of REQ-028 -> accepted without ADJACENCY_CHECK_EN; conflito_memoria=1 with it.
REQ-030 SHALL cover: 11 submarinos for jogador 1, then a 12th -> frota_cheia=1, while a jogador 0 request is still accepted.
REQ-031 SHALL cover: rst_n low during SCAN -> req_ready=1 next cycle, fill counters 0, wr_en never asserted.
